// File: rtl/mem_port_arbiter.sv
// Merges the core's instruction-read, data-read and data-write streams onto one
// shared memory port. Priority is write > data read > instruction read, and each request is bounded by a timeout.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_WSTRB,
  output logic [31:0] M_WDATA,
  input  logic        M_READY,
  input  logic        M_RVALID,
  input  logic [31:0] M_RDATA,
  output logic        ERR
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {SEL_WR, SEL_DR, SEL_IR} sel_t;

  localparam logic [15:0] TLAST = TIMEOUT - 16'd1;

  state_t      state_q;
  sel_t        sel_q;
  logic [2:0]  pend_q;
  logic [15:0] cnt_q;
  logic [31:0] waddr_q, wdata_q, draddr_q, iraddr_q;
  logic [3:0]  wstrb_q;

  logic [31:0] inst_roaddr_q, inst_rdata_q, data_roaddr_q, data_rdata_q;
  logic        inst_rvalid_q, data_rvalid_q, err_q;
  logic        m_req_q, m_we_q;
  logic [31:0] m_addr_q, m_wdata_q;
  logic [3:0]  m_wstrb_q;

  logic        expire;
  logic        retire;
  logic        timed_out;
  logic [31:0] rsp_data_d;

  // A request retires on write acceptance, on read data, or when the timer expires;
  // a real completion in the expiry cycle takes precedence.
  always_comb begin
    expire     = (TIMEOUT != 16'd0) && (cnt_q == TLAST);
    retire     = 1'b0;
    timed_out  = 1'b0;
    rsp_data_d = 32'h0;
    case (state_q)
      REQ: begin
        if (M_READY) begin
          retire = (sel_q == SEL_WR);
        end else if (expire) begin
          retire    = 1'b1;
          timed_out = 1'b1;
        end
      end
      RESP: begin
        if (M_RVALID) begin
          retire     = 1'b1;
          rsp_data_d = M_RDATA;
        end else if (expire) begin
          retire    = 1'b1;
          timed_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      sel_q         <= SEL_WR;
      pend_q        <= 3'b000;
      cnt_q         <= 16'h0;
      waddr_q       <= 32'h0;
      wdata_q       <= 32'h0;
      draddr_q      <= 32'h0;
      iraddr_q      <= 32'h0;
      wstrb_q       <= 4'h0;
      inst_roaddr_q <= 32'h0;
      inst_rdata_q  <= 32'h0;
      data_roaddr_q <= 32'h0;
      data_rdata_q  <= 32'h0;
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      err_q         <= 1'b0;
      m_req_q       <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= 32'h0;
      m_wstrb_q     <= 4'h0;
      m_wdata_q     <= 32'h0;
    end else begin
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      err_q         <= 1'b0;

      // A new set is only taken once every previously captured request has retired.
      if ((pend_q == 3'b000) && (DATA_WREN || DATA_RDEN || INST_RDEN)) begin
        pend_q   <= {DATA_WREN, DATA_RDEN, INST_RDEN};
        waddr_q  <= DATA_WADDR;
        wdata_q  <= DATA_WDATA;
        wstrb_q  <= DATA_WSTRB;
        draddr_q <= DATA_RIADDR;
        iraddr_q <= INST_RIADDR;
      end

      case (state_q)
        IDLE: begin
          if (pend_q != 3'b000) begin
            state_q <= REQ;
            cnt_q   <= 16'h0;
            m_req_q <= 1'b1;
            if (pend_q[2]) begin
              sel_q     <= SEL_WR;
              m_we_q    <= 1'b1;
              m_addr_q  <= waddr_q;
              m_wstrb_q <= wstrb_q;
              m_wdata_q <= wdata_q;
            end else if (pend_q[1]) begin
              sel_q     <= SEL_DR;
              m_we_q    <= 1'b0;
              m_addr_q  <= draddr_q;
              m_wstrb_q <= 4'h0;
              m_wdata_q <= 32'h0;
            end else begin
              sel_q     <= SEL_IR;
              m_we_q    <= 1'b0;
              m_addr_q  <= iraddr_q;
              m_wstrb_q <= 4'h0;
              m_wdata_q <= 32'h0;
            end
          end
        end
        REQ, RESP: begin
          if (retire) begin
            state_q <= IDLE;
            m_req_q <= 1'b0;
            err_q   <= timed_out;
            case (sel_q)
              SEL_WR: pend_q[2] <= 1'b0;
              SEL_DR: begin
                pend_q[1]     <= 1'b0;
                data_rvalid_q <= 1'b1;
                data_rdata_q  <= rsp_data_d;
                data_roaddr_q <= draddr_q;
              end
              default: begin
                pend_q[0]     <= 1'b0;
                inst_rvalid_q <= 1'b1;
                inst_rdata_q  <= rsp_data_d;
                inst_roaddr_q <= iraddr_q;
              end
            endcase
          end else if ((state_q == REQ) && M_READY) begin
            state_q <= RESP;
            m_req_q <= 1'b0;
            cnt_q   <= 16'h0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MEM_WAIT    = |pend_q;
  assign INST_ROADDR = inst_roaddr_q;
  assign INST_RVALID = inst_rvalid_q;
  assign INST_RDATA  = inst_rdata_q;
  assign DATA_ROADDR = data_roaddr_q;
  assign DATA_RVALID = data_rvalid_q;
  assign DATA_RDATA  = data_rdata_q;
  assign M_REQ       = m_req_q;
  assign M_WE        = m_we_q;
  assign M_ADDR      = m_addr_q;
  assign M_WSTRB     = m_wstrb_q;
  assign M_WDATA     = m_wdata_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a latency-programmable memory responder plus a
// transaction-level model of the expected issue order, response data and timeouts.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam logic [15:0] TO = 16'd8;

  typedef struct {
    bit          hangReq;
    bit          hangResp;
    int          readyDelay;
    int          respDelay;
    logic [68:0] expIssue;
  } plan_t;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } evt_t;

  typedef struct {
    bit          en;
    logic [31:0] addr;
    int          hang;
    int          rdy;
    int          rsp;
  } reqSpec_t;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic instRden = 1'b0, dataRden = 1'b0, dataWren = 1'b0;
  logic [31:0] instRiaddr = '0, dataRiaddr = '0, dataWaddr = '0, dataWdata = '0;
  logic [3:0]  dataWstrb = '0;
  logic [31:0] instRoaddr, instRdata, dataRoaddr, dataRdata, mAddr, mWdata;
  logic        instRvalid, dataRvalid, memWait, mReq, mWe, err;
  logic [3:0]  mWstrb;
  logic        mReady = 1'b0, mRvalid = 1'b0;
  logic [31:0] mRdata = '0;
  logic [255:0] allOut;

  int checkCount = 0;
  int errorCount = 0;

  plan_t       planQ[$];
  plan_t       cur;
  bit          rspBusy = 1'b0;
  int          rspPhase = 0;
  int          rspCnt = 0;
  logic [31:0] rspAddr = '0;
  logic [31:0] memArr [int unsigned];
  logic [31:0] refMem [int unsigned];
  logic [31:0] lastDAddr = '0, lastDData = '0, lastIAddr = '0, lastIData = '0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(clock), .RST(resetN),
    .INST_RDEN(instRden), .INST_RIADDR(instRiaddr), .INST_ROADDR(instRoaddr),
    .INST_RVALID(instRvalid), .INST_RDATA(instRdata),
    .DATA_RDEN(dataRden), .DATA_RIADDR(dataRiaddr), .DATA_ROADDR(dataRoaddr),
    .DATA_RVALID(dataRvalid), .DATA_RDATA(dataRdata),
    .DATA_WREN(dataWren), .DATA_WSTRB(dataWstrb), .DATA_WADDR(dataWaddr), .DATA_WDATA(dataWdata),
    .MEM_WAIT(memWait), .M_REQ(mReq), .M_WE(mWe), .M_ADDR(mAddr), .M_WSTRB(mWstrb),
    .M_WDATA(mWdata), .M_READY(mReady), .M_RVALID(mRvalid), .M_RDATA(mRdata), .ERR(err)
  );

  assign allOut = {54'h0, instRoaddr, instRvalid, instRdata, dataRoaddr, dataRvalid, dataRdata,
                   memWait, mReq, mWe, mAddr, mWstrb, mWdata, err};

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memInit(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : memInit(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : memInit(a);
  endfunction

  // Memory side: follows the plan queue in issue order and checks every cycle of each request.
  always @(negedge clock) begin
    mReady  = 1'b0;
    mRvalid = 1'b0;
    mRdata  = $urandom();
    if (!resetN) begin
      rspBusy = 1'b0;
    end else begin
      if (!rspBusy && mReq) begin
        checkOutput("reqExpected", planQ.size() != 0, 1'b1);
        if (planQ.size() != 0) begin
          cur      = planQ.pop_front();
          rspBusy  = 1'b1;
          rspPhase = 0;
          rspCnt   = 0;
        end
      end
      if (rspBusy && rspPhase == 0) begin
        if (!mReq) begin
          rspBusy = 1'b0;
        end else begin
          checkOutput("issue", {mWe, mAddr, mWstrb, (mWe ? mWdata : 32'h0)}, cur.expIssue);
          if (!cur.hangReq && rspCnt == cur.readyDelay) begin
            mReady = 1'b1;
            if (mWe) begin
              memArr[mAddr] = mergeBytes(memRead(mAddr), mWdata, mWstrb);
              rspBusy = 1'b0;
            end else begin
              rspPhase = 1;
              rspCnt   = 0;
              rspAddr  = mAddr;
            end
          end else begin
            rspCnt++;
          end
        end
      end else if (rspBusy && rspPhase == 1) begin
        if (cur.hangResp) begin
          rspBusy = 1'b0;
        end else if (rspCnt == cur.respDelay) begin
          mRvalid = 1'b1;
          mRdata  = memRead(rspAddr);
          rspBusy = 1'b0;
        end else begin
          rspCnt++;
        end
      end
    end
  end

  task automatic driveIdle();
    instRden = 1'b0; dataRden = 1'b0; dataWren = 1'b0;
  endtask

  task automatic driveNoise();
    instRden   = 1'($urandom_range(0, 1));
    dataRden   = 1'($urandom_range(0, 1));
    dataWren   = 1'($urandom_range(0, 1));
    instRiaddr = $urandom();
    dataRiaddr = $urandom();
    dataWaddr  = $urandom();
    dataWdata  = $urandom();
    dataWstrb  = 4'($urandom_range(0, 15));
  endtask

  // Called on a negedge with MEM_WAIT low; returns on the negedge where MEM_WAIT is low again.
  task automatic applyStimulus(input reqSpec_t w, input reqSpec_t d, input reqSpec_t i,
                               input logic [31:0] wData, input logic [3:0] wStrb,
                               input bit noise, output int lastEvtCycle);
    plan_t p;
    evt_t  e;
    evt_t  expQ[$];
    int    idx, cyc;
    bit    done;
    expQ = {};
    if (w.en) begin
      p.hangReq = (w.hang != 0); p.hangResp = 1'b0;
      p.readyDelay = w.rdy; p.respDelay = 0;
      p.expIssue = {1'b1, w.addr, wStrb, wData};
      planQ.push_back(p);
      if (w.hang != 0) begin
        e.port = 2'd0; e.addr = 32'h0; e.data = 32'h0; e.err = 1'b1;
        expQ.push_back(e);
      end else begin
        refMem[w.addr] = mergeBytes(refRead(w.addr), wData, wStrb);
      end
    end
    if (d.en) begin
      p.hangReq = (d.hang == 1); p.hangResp = (d.hang == 2);
      p.readyDelay = d.rdy; p.respDelay = d.rsp;
      p.expIssue = {1'b0, d.addr, 4'h0, 32'h0};
      planQ.push_back(p);
      e.port = 2'd1; e.addr = d.addr; e.data = (d.hang != 0) ? 32'h0 : refRead(d.addr);
      e.err = (d.hang != 0);
      expQ.push_back(e);
      lastDAddr = e.addr; lastDData = e.data;
    end
    if (i.en) begin
      p.hangReq = (i.hang == 1); p.hangResp = (i.hang == 2);
      p.readyDelay = i.rdy; p.respDelay = i.rsp;
      p.expIssue = {1'b0, i.addr, 4'h0, 32'h0};
      planQ.push_back(p);
      e.port = 2'd2; e.addr = i.addr; e.data = (i.hang != 0) ? 32'h0 : refRead(i.addr);
      e.err = (i.hang != 0);
      expQ.push_back(e);
      lastIAddr = e.addr; lastIData = e.data;
    end

    dataWren = w.en; dataWaddr = w.addr; dataWdata = wData; dataWstrb = wStrb;
    dataRden = d.en; dataRiaddr = d.addr;
    instRden = i.en; instRiaddr = i.addr;

    cyc = 0; idx = 0; done = 1'b0; lastEvtCycle = -1;
    while (!done && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) checkOutput("waitRise", memWait, 1'b1);
      if (err || dataRvalid || instRvalid) begin
        checkOutput("oneValid", dataRvalid & instRvalid, 1'b0);
        e.port = dataRvalid ? 2'd1 : (instRvalid ? 2'd2 : 2'd0);
        e.addr = dataRvalid ? dataRoaddr : instRoaddr;
        e.data = dataRvalid ? dataRdata : instRdata;
        e.err  = err;
        if (idx < expQ.size()) begin
          checkOutput("evtKind", {e.port, e.err}, {expQ[idx].port, expQ[idx].err});
          if (expQ[idx].port != 2'd0)
            checkOutput("evtData", {e.addr, e.data}, {expQ[idx].addr, expQ[idx].data});
          checkOutput("waitAtEvt", memWait, idx != expQ.size() - 1);
        end else begin
          checkOutput("extraEvt", idx, expQ.size());
        end
        idx++;
        lastEvtCycle = cyc;
      end
      if (!memWait) begin
        done = 1'b1;
        driveIdle();
      end else if (noise) begin
        driveNoise();
      end else begin
        driveIdle();
      end
    end
    checkOutput("setDone", done, 1'b1);
    checkOutput("evtCount", idx, expQ.size());
    checkOutput("plansUsed", planQ.size(), 0);
    checkOutput("dHold", {dataRoaddr, dataRdata}, {lastDAddr, lastDData});
    checkOutput("iHold", {instRoaddr, instRdata}, {lastIAddr, lastIData});
    planQ = {};
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reqSpec_t w, d, i, off;
    int       last, m;
    off = '{en: 1'b0, addr: 32'h0, hang: 0, rdy: 0, rsp: 0};

    #1;
    checkOutput("resetState", allOut, 256'h0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;

    // Single instruction read returning DEADBEEF.
    memArr[32'h100] = 32'hDEADBEEF;
    refMem[32'h100] = 32'hDEADBEEF;
    i = '{en: 1'b1, addr: 32'h100, hang: 0, rdy: 1, rsp: 1};
    applyStimulus(off, off, i, 32'h0, 4'h0, 1'b0, last);
    checkOutput("irLatency", last, 6);

    // Write, data read and instruction read captured together; read sees the new write.
    w = '{en: 1'b1, addr: 32'h200, hang: 0, rdy: 0, rsp: 0};
    d = '{en: 1'b1, addr: 32'h200, hang: 0, rdy: 0, rsp: 0};
    i = '{en: 1'b1, addr: 32'h0,   hang: 0, rdy: 0, rsp: 0};
    applyStimulus(w, d, i, 32'h11223344, 4'hF, 1'b0, last);

    // Ready withheld for five cycles on a partial-strobe write.
    w = '{en: 1'b1, addr: 32'h600, hang: 0, rdy: 5, rsp: 0};
    d = '{en: 1'b1, addr: 32'h600, hang: 0, rdy: 2, rsp: 3};
    applyStimulus(w, d, off, 32'hA1B2C3D4, 4'h5, 1'b0, last);

    // Read response never arrives.
    d = '{en: 1'b1, addr: 32'h500, hang: 2, rdy: 0, rsp: 0};
    applyStimulus(off, d, off, 32'h0, 4'h0, 1'b0, last);
    checkOutput("errLatency", last, 11);

    // Requests toggled under MEM_WAIT, then an immediate back-to-back capture.
    d = '{en: 1'b1, addr: 32'h300, hang: 0, rdy: 1, rsp: 2};
    applyStimulus(off, d, off, 32'h0, 4'h0, 1'b1, last);
    i = '{en: 1'b1, addr: 32'h100, hang: 0, rdy: 0, rsp: 0};
    applyStimulus(off, off, i, 32'h0, 4'h0, 1'b1, last);

    // Asynchronous reset while a read waits for its response.
    p_reset : begin
      plan_t p;
      p.hangReq = 1'b0; p.hangResp = 1'b1; p.readyDelay = 0; p.respDelay = 0;
      p.expIssue = {1'b0, 32'h400, 4'h0, 32'h0};
      planQ.push_back(p);
      dataRden = 1'b1; dataRiaddr = 32'h400;
      @(negedge clock);
      driveIdle();
      repeat (3) @(negedge clock);
      #2 resetN = 1'b0;
      #1 checkOutput("asyncReset", allOut, 256'h0);
      repeat (2) @(negedge clock);
      #2 resetN = 1'b1;
      planQ = {};
      lastDAddr = '0; lastDData = '0; lastIAddr = '0; lastIData = '0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clock);
        checkOutput("quietAfterReset", {memWait, err, dataRvalid, instRvalid}, 4'h0);
      end
      i = '{en: 1'b1, addr: 32'h104, hang: 0, rdy: 0, rsp: 1};
      applyStimulus(off, off, i, 32'h0, 4'h0, 1'b0, last);
    end

    for (int n = 0; n < 40; n++) begin
      m = $urandom_range(1, 7);
      w.en = m[2]; d.en = m[1]; i.en = m[0];
      w.addr = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      d.addr = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      i.addr = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      w.hang = ($urandom_range(0, 9) == 0) ? 1 : 0;
      d.hang = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      i.hang = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      w.rdy = $urandom_range(0, 5); d.rdy = $urandom_range(0, 5); i.rdy = $urandom_range(0, 5);
      w.rsp = 0; d.rsp = $urandom_range(0, 5); i.rsp = $urandom_range(0, 5);
      applyStimulus(w, d, i, $urandom(), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), last);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Merges the core's three memory request streams (instruction read, data read, data write) onto a single shared memory port.
- Sits between the core's physical-address memory interface and a single-ported bus or memory.
- Generates MEM_WAIT toward the core while captured requests are outstanding.
- Serialises requests with a fixed write > data-read > instruction-read order, guarded by a response timeout.

Parameters:
TIMEOUT, 16'd1024, cycles to wait for M_READY or M_RVALID before forcing completion; 0 disables the timeout.

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  reset; asynchronous, active-low
INST_RDEN  in  1  instruction read request
INST_RIADDR  in  32  instruction read address
INST_ROADDR  out  32  address of the returned instruction
INST_RVALID  out  1  instruction data valid, 1-cycle pulse
INST_RDATA  out  32  instruction data
DATA_RDEN  in  1  data read request
DATA_RIADDR  in  32  data read address
DATA_ROADDR  out  32  address of the returned data
DATA_RVALID  out  1  data valid, 1-cycle pulse
DATA_RDATA  out  32  read data
DATA_WREN  in  1  data write request
DATA_WSTRB  in  4  write byte strobes
DATA_WADDR  in  32  write address
DATA_WDATA  in  32  write data
MEM_WAIT  out  1  core stall; high while any captured request is pending
M_REQ  out  1  shared-port request
M_WE  out  1  1 = write, 0 = read
M_ADDR  out  32  shared-port address
M_WSTRB  out  4  shared-port strobes (4'h0 on reads)
M_WDATA  out  32  shared-port write data
M_READY  in  1  request accepted this cycle
M_RVALID  in  1  read response valid
M_RDATA  in  32  read response data
ERR  out  1  timeout pulse, 1 cycle

Behaviour:
- Reset (RST low, asynchronous): state IDLE; pending bits cleared; timeout counter 0. All outputs 0, including MEM_WAIT, M_REQ and both RVALIDs.
- Capture:
  - Happens on any edge where pending == 3'b000 and at least one of DATA_WREN, DATA_RDEN or INST_RDEN is high.
  - Latches pend_wr/pend_dr/pend_ir plus all addresses, strobes and write data.
  - Requests presented while pending is nonzero are ignored; the core holds them under MEM_WAIT and they are captured on the first cycle pending is empty.
- MEM_WAIT = |pending (registered bits). It rises the cycle after capture.
- States:
  - IDLE: if any pending bit is set, select the highest-priority one (wr, then dr, then ir), drive the M_* fields and go to REQ. Zero-cycle dispatch is not required; IDLE→REQ takes one cycle.
  - REQ: M_REQ = 1 with stable fields until M_READY.
    - Write + M_READY: clear pend_wr, return to IDLE.
    - Read + M_READY: go to RESP.
  - RESP: M_REQ = 0; wait for M_RVALID. M_RVALID is ignored outside RESP.
    - On M_RVALID: register M_RDATA into the selected port's RDATA, set ROADDR to the captured address, pulse RVALID for 1 cycle, clear that pending bit, return to IDLE.
- MEM_WAIT falls in the same cycle the last RVALID pulses (or the cycle after the last write is accepted).
- RDATA and ROADDR hold their values until the next response on that port.
- Timeout:
  - The counter resets on entry to REQ or RESP and increments each cycle in those states.
  - When counter == TIMEOUT-1 and TIMEOUT != 0: ERR pulses; the current request completes (a read returns RDATA = 32'h0 with RVALID; a write is dropped); the pending bit clears; return to IDLE.
  - A completion event in the same cycle wins over the timeout (no ERR).
- Ordering: a write preceding a read of the same address in one captured set is issued first, giving read-after-write coherence.
- Reset mid-transaction: everything is abandoned immediately. No RVALID is produced for the aborted request.

Test Plan:
- Only INST_RDEN, addr 32'h100; M_READY 1 cycle after M_REQ; M_RVALID 2 cycles later with 32'hDEADBEEF -> INST_RVALID pulse, INST_ROADDR = 32'h100, INST_RDATA = 32'hDEADBEEF; MEM_WAIT low that cycle.
- All three requests in one cycle (W 0x200 = 0x11223344 strb 4'hF, DR 0x200, IR 0x0) -> M_* sequence write, then read 0x200, then read 0x0; DATA_RVALID precedes INST_RVALID; MEM_WAIT high until INST_RVALID.
- M_READY held low 5 cycles -> M_REQ, M_ADDR and M_WDATA stable throughout; the write issues once.
- TIMEOUT = 8, M_RVALID never asserted -> ERR pulse 8 cycles into RESP, DATA_RVALID with DATA_RDATA = 0, pending cleared.
- RST driven low during RESP, then released -> all outputs 0 with no clock edge needed; no RVALID follows; a new request is captured normally.
- New INST_RDEN toggled while MEM_WAIT is high -> ignored; captured on the first cycle MEM_WAIT is low.
